// File: rtl/id_ex_stage.sv
// ID stage for an RV32I int/load/store/LUI/AUIPC subset with the ID/EX pipeline register.
// Reads the regfile, forwards from EX/MEM, requests load-use stalls and registers the bundle for EX.
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [31:0]        inst_i,
  input  logic               inst_valid_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               reg1_read_o,
  output logic [RADDR_W-1:0] reg1_addr_o,
  input  logic [XLEN-1:0]    reg1_data_i,
  output logic               reg2_read_o,
  output logic [RADDR_W-1:0] reg2_addr_o,
  input  logic [XLEN-1:0]    reg2_data_i,
  input  logic               ex_fwd_we_i,
  input  logic [RADDR_W-1:0] ex_fwd_waddr_i,
  input  logic [XLEN-1:0]    ex_fwd_wdata_i,
  input  logic               mem_fwd_we_i,
  input  logic [RADDR_W-1:0] mem_fwd_waddr_i,
  input  logic [XLEN-1:0]    mem_fwd_wdata_i,
  output logic               stallreq_o,
  output logic               ex_valid_o,
  output logic [XLEN-1:0]    ex_pc_o,
  output logic [3:0]         ex_aluop_o,
  output logic [XLEN-1:0]    ex_op1_o,
  output logic [XLEN-1:0]    ex_op2_o,
  output logic [XLEN-1:0]    ex_sdata_o,
  output logic [1:0]         ex_memop_o,
  output logic [2:0]         ex_funct3_o,
  output logic [RADDR_W-1:0] ex_rd_o,
  output logic               ex_wreg_o,
  output logic               ex_illegal_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  // Register-register ops use inst[30] for SUB/SRA; immediate ops only for SRAI.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic b30,
                                            input logic is_reg);
    logic [3:0] op;
    case (f3)
      3'd0:    op = (is_reg && b30) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = b30 ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // WB bypass lives in the regfile, so only EX (youngest) then MEM are checked here.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic               rd_en,
    input logic [RADDR_W-1:0] addr,
    input logic [XLEN-1:0]    rf_data,
    input logic               ex_we,
    input logic [RADDR_W-1:0] ex_addr,
    input logic [XLEN-1:0]    ex_data,
    input logic               mem_we,
    input logic [RADDR_W-1:0] mem_addr,
    input logic [XLEN-1:0]    mem_data
  );
    logic [XLEN-1:0] v;
    if (!rd_en || addr == '0)            v = '0;
    else if (ex_we && ex_addr == addr)   v = ex_data;
    else if (mem_we && mem_addr == addr) v = mem_data;
    else                                 v = rf_data;
    return v;
  endfunction

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [RADDR_W-1:0] rd;
  logic [XLEN-1:0]    imm_i;
  logic [XLEN-1:0]    imm_s;
  logic [XLEN-1:0]    imm_u;
  logic [XLEN-1:0]    shamt;
  logic [XLEN-1:0]    rs1_val;
  logic [XLEN-1:0]    rs2_val;

  assign opcode      = inst_i[6:0];
  assign funct3      = inst_i[14:12];
  assign rd          = inst_i[11:7];
  assign reg1_addr_o = inst_i[19:15];
  assign reg2_addr_o = inst_i[24:20];
  assign imm_i       = XLEN'($signed(inst_i[31:20]));
  assign imm_s       = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
  assign imm_u       = XLEN'($signed({inst_i[31:12], 12'b0}));
  assign shamt       = XLEN'(inst_i[24:20]);

  assign reg1_read_o = (opcode == OPC_OP) || (opcode == OPC_OPIMM) ||
                       (opcode == OPC_LOAD) || (opcode == OPC_STORE);
  assign reg2_read_o = (opcode == OPC_OP) || (opcode == OPC_STORE);

  assign rs1_val = fwd_sel(reg1_read_o, reg1_addr_o, reg1_data_i,
                           ex_fwd_we_i, ex_fwd_waddr_i, ex_fwd_wdata_i,
                           mem_fwd_we_i, mem_fwd_waddr_i, mem_fwd_wdata_i);
  assign rs2_val = fwd_sel(reg2_read_o, reg2_addr_o, reg2_data_i,
                           ex_fwd_we_i, ex_fwd_waddr_i, ex_fwd_wdata_i,
                           mem_fwd_we_i, mem_fwd_waddr_i, mem_fwd_wdata_i);

  logic [3:0]      dec_aluop;
  logic [XLEN-1:0] dec_op1;
  logic [XLEN-1:0] dec_op2;
  logic [1:0]      dec_memop;
  logic            dec_wreg;
  logic            dec_illegal;

  always_comb begin
    dec_aluop   = ALU_ADD;
    dec_op1     = '0;
    dec_op2     = '0;
    dec_memop   = MEM_NONE;
    dec_wreg    = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_aluop = alu_decode(funct3, inst_i[30], 1'b1);
        dec_op1   = rs1_val;
        dec_op2   = rs2_val;
        dec_wreg  = 1'b1;
      end
      OPC_OPIMM: begin
        dec_aluop = alu_decode(funct3, inst_i[30], 1'b0);
        dec_op1   = rs1_val;
        dec_op2   = (funct3 == 3'd1 || funct3 == 3'd5) ? shamt : imm_i;
        dec_wreg  = 1'b1;
      end
      OPC_LOAD: begin
        dec_op1   = rs1_val;
        dec_op2   = imm_i;
        dec_memop = MEM_LOAD;
        dec_wreg  = 1'b1;
      end
      OPC_STORE: begin
        dec_op1   = rs1_val;
        dec_op2   = imm_s;
        dec_memop = MEM_STORE;
      end
      OPC_LUI: begin
        dec_op2  = imm_u;
        dec_wreg = 1'b1;
      end
      OPC_AUIPC: begin
        dec_op1  = pc_i;
        dec_op2  = imm_u;
        dec_wreg = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (rd == '0) dec_wreg = 1'b0;
  end

  logic               ex_valid_q,   ex_valid_d;
  logic [XLEN-1:0]    ex_pc_q,      ex_pc_d;
  logic [3:0]         ex_aluop_q,   ex_aluop_d;
  logic [XLEN-1:0]    ex_op1_q,     ex_op1_d;
  logic [XLEN-1:0]    ex_op2_q,     ex_op2_d;
  logic [XLEN-1:0]    ex_sdata_q,   ex_sdata_d;
  logic [1:0]         ex_memop_q,   ex_memop_d;
  logic [2:0]         ex_funct3_q,  ex_funct3_d;
  logic [RADDR_W-1:0] ex_rd_q,      ex_rd_d;
  logic               ex_wreg_q,    ex_wreg_d;
  logic               ex_illegal_q, ex_illegal_d;

  // Only a load already sitting in EX can hazard; its data is on MEM forwarding one cycle later.
  assign stallreq_o = inst_valid_i && ex_valid_q && (ex_memop_q == MEM_LOAD) &&
                      (ex_rd_q != '0) &&
                      ((reg1_read_o && reg1_addr_o == ex_rd_q) ||
                       (reg2_read_o && reg2_addr_o == ex_rd_q));

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_aluop_d   = ex_aluop_q;
    ex_op1_d     = ex_op1_q;
    ex_op2_d     = ex_op2_q;
    ex_sdata_d   = ex_sdata_q;
    ex_memop_d   = ex_memop_q;
    ex_funct3_d  = ex_funct3_q;
    ex_rd_d      = ex_rd_q;
    ex_wreg_d    = ex_wreg_q;
    ex_illegal_d = ex_illegal_q;
    if (flush_i || (!stall_i && stallreq_o)) begin
      ex_valid_d   = 1'b0;
      ex_wreg_d    = 1'b0;
      ex_memop_d   = MEM_NONE;
      ex_illegal_d = 1'b0;
    end else if (!stall_i) begin
      ex_valid_d   = inst_valid_i;
      ex_pc_d      = pc_i;
      ex_aluop_d   = dec_aluop;
      ex_op1_d     = dec_op1;
      ex_op2_d     = dec_op2;
      ex_sdata_d   = rs2_val;
      ex_memop_d   = inst_valid_i ? dec_memop : MEM_NONE;
      ex_funct3_d  = funct3;
      ex_rd_d      = rd;
      ex_wreg_d    = inst_valid_i && dec_wreg;
      ex_illegal_d = inst_valid_i && dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_aluop_q   <= '0;
      ex_op1_q     <= '0;
      ex_op2_q     <= '0;
      ex_sdata_q   <= '0;
      ex_memop_q   <= '0;
      ex_funct3_q  <= '0;
      ex_rd_q      <= '0;
      ex_wreg_q    <= 1'b0;
      ex_illegal_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_aluop_q   <= ex_aluop_d;
      ex_op1_q     <= ex_op1_d;
      ex_op2_q     <= ex_op2_d;
      ex_sdata_q   <= ex_sdata_d;
      ex_memop_q   <= ex_memop_d;
      ex_funct3_q  <= ex_funct3_d;
      ex_rd_q      <= ex_rd_d;
      ex_wreg_q    <= ex_wreg_d;
      ex_illegal_q <= ex_illegal_d;
    end
  end

  assign ex_valid_o   = ex_valid_q;
  assign ex_pc_o      = ex_pc_q;
  assign ex_aluop_o   = ex_aluop_q;
  assign ex_op1_o     = ex_op1_q;
  assign ex_op2_o     = ex_op2_q;
  assign ex_sdata_o   = ex_sdata_q;
  assign ex_memop_o   = ex_memop_q;
  assign ex_funct3_o  = ex_funct3_q;
  assign ex_rd_o      = ex_rd_q;
  assign ex_wreg_o    = ex_wreg_q;
  assign ex_illegal_o = ex_illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random instruction streams against a reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, inst_i;
  logic        inst_valid_i, stall_i, flush_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_fwd_we_i, mem_fwd_we_i;
  logic [4:0]  ex_fwd_waddr_i, mem_fwd_waddr_i;
  logic [31:0] ex_fwd_wdata_i, mem_fwd_wdata_i;
  logic        stallreq_o, ex_valid_o, ex_wreg_o, ex_illegal_o;
  logic [31:0] ex_pc_o, ex_op1_o, ex_op2_o, ex_sdata_o;
  logic [3:0]  ex_aluop_o;
  logic [1:0]  ex_memop_o;
  logic [2:0]  ex_funct3_o;
  logic [4:0]  ex_rd_o;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .reg1_read_o(reg1_read_o), .reg1_addr_o(reg1_addr_o), .reg1_data_i(reg1_data_i),
    .reg2_read_o(reg2_read_o), .reg2_addr_o(reg2_addr_o), .reg2_data_i(reg2_data_i),
    .ex_fwd_we_i(ex_fwd_we_i), .ex_fwd_waddr_i(ex_fwd_waddr_i), .ex_fwd_wdata_i(ex_fwd_wdata_i),
    .mem_fwd_we_i(mem_fwd_we_i), .mem_fwd_waddr_i(mem_fwd_waddr_i), .mem_fwd_wdata_i(mem_fwd_wdata_i),
    .stallreq_o(stallreq_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_aluop_o(ex_aluop_o),
    .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o), .ex_sdata_o(ex_sdata_o), .ex_memop_o(ex_memop_o),
    .ex_funct3_o(ex_funct3_o), .ex_rd_o(ex_rd_o), .ex_wreg_o(ex_wreg_o), .ex_illegal_o(ex_illegal_o)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  aluop;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] sdata;
    logic [1:0]  memop;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        wreg;
    logic        ill;
  } bundle_t;

  bundle_t m;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Value an instruction sees for a source register after EX/MEM bypassing.
  function automatic logic [31:0] src_val(input bit en, input logic [4:0] a, input logic [31:0] rf);
    if (!en || a == 0) return 32'd0;
    if (ex_fwd_we_i && ex_fwd_waddr_i == a) return ex_fwd_wdata_i;
    if (mem_fwd_we_i && mem_fwd_waddr_i == a) return mem_fwd_wdata_i;
    return rf;
  endfunction

  // ISA mnemonic order ADD SUB SLL SLT SLTU XOR SRL SRA OR AND.
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input bit alt, input bit reg_form);
    logic [3:0] tbl [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (f3 == 0 && alt && reg_form) return 4'd1;
    if (f3 == 5 && alt) return 4'd7;
    return tbl[f3];
  endfunction

  task automatic ref_decode(output bundle_t b, output bit r1, output bit r2);
    logic [6:0]  opc = inst_i[6:0];
    logic [31:0] ii  = {{20{inst_i[31]}}, inst_i[31:20]};
    logic [31:0] si  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    logic [31:0] ui  = {inst_i[31:12], 12'd0};
    b = '0;
    b.pc = pc_i; b.f3 = inst_i[14:12]; b.rd = inst_i[11:7];
    r1 = (opc == 7'h33 || opc == 7'h13 || opc == 7'h03 || opc == 7'h23);
    r2 = (opc == 7'h33 || opc == 7'h23);
    b.sdata = src_val(r2, inst_i[24:20], reg2_data_i);
    case (opc)
      7'h33: begin
        b.op1 = src_val(1, inst_i[19:15], reg1_data_i); b.op2 = b.sdata;
        b.aluop = alu_of(b.f3, inst_i[30], 1); b.wreg = 1;
      end
      7'h13: begin
        b.op1 = src_val(1, inst_i[19:15], reg1_data_i);
        b.op2 = (b.f3 == 1 || b.f3 == 5) ? {27'd0, inst_i[24:20]} : ii;
        b.aluop = alu_of(b.f3, inst_i[30], 0); b.wreg = 1;
      end
      7'h03: begin b.op1 = src_val(1, inst_i[19:15], reg1_data_i); b.op2 = ii; b.memop = 1; b.wreg = 1; end
      7'h23: begin b.op1 = src_val(1, inst_i[19:15], reg1_data_i); b.op2 = si; b.memop = 2; end
      7'h37: begin b.op2 = ui; b.wreg = 1; end
      7'h17: begin b.op1 = pc_i; b.op2 = ui; b.wreg = 1; end
      default: b.ill = 1;
    endcase
    if (b.rd == 0) b.wreg = 0;
  endtask

  task automatic check_all();
    check_eq("ex_valid", ex_valid_o, m.valid);
    check_eq("ex_pc", ex_pc_o, m.pc);
    check_eq("ex_aluop", ex_aluop_o, m.aluop);
    check_eq("ex_op1", ex_op1_o, m.op1);
    check_eq("ex_op2", ex_op2_o, m.op2);
    check_eq("ex_sdata", ex_sdata_o, m.sdata);
    check_eq("ex_memop", ex_memop_o, m.memop);
    check_eq("ex_funct3", ex_funct3_o, m.f3);
    check_eq("ex_rd", ex_rd_o, m.rd);
    check_eq("ex_wreg", ex_wreg_o, m.wreg);
    check_eq("ex_illegal", ex_illegal_o, m.ill);
  endtask

  function automatic bit ref_stallreq(input bit r1, input bit r2);
    return inst_valid_i && m.valid && m.memop == 1 && m.rd != 0 &&
           ((r1 && inst_i[19:15] == m.rd) || (r2 && inst_i[24:20] == m.rd));
  endfunction

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle();
    bundle_t d, nm;
    bit r1, r2, sreq;
    #1;
    ref_decode(d, r1, r2);
    sreq = ref_stallreq(r1, r2);
    check_eq("reg1_read", reg1_read_o, r1);
    check_eq("reg2_read", reg2_read_o, r2);
    check_eq("reg1_addr", reg1_addr_o, inst_i[19:15]);
    check_eq("reg2_addr", reg2_addr_o, inst_i[24:20]);
    check_eq("stallreq", stallreq_o, sreq);
    nm = m;
    if (flush_i || (!stall_i && sreq)) begin
      nm.valid = 0; nm.wreg = 0; nm.memop = 0; nm.ill = 0;
    end else if (!stall_i) begin
      nm = d;
      nm.valid = inst_valid_i;
      if (!inst_valid_i) begin nm.wreg = 0; nm.memop = 0; nm.ill = 0; end
    end
    @(posedge clk);
    #1;
    m = nm;
    check_all();
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    inst_i = inst; pc_i = pc; inst_valid_i = 1'b1;
  endtask

  task automatic quiet_fwd();
    ex_fwd_we_i = 0; ex_fwd_waddr_i = 0; ex_fwd_wdata_i = 0;
    mem_fwd_we_i = 0; mem_fwd_waddr_i = 0; mem_fwd_wdata_i = 0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] rs1 = 5'($urandom_range(0, 3));
    logic [4:0] rs2 = 5'($urandom_range(0, 3));
    logic [4:0] rd  = 5'($urandom_range(0, 3));
    logic [2:0] f3  = 3'($urandom_range(0, 7));
    logic [11:0] imm = 12'($urandom);
    logic [6:0] alt = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    logic [6:0] bad [6] = '{7'h63, 7'h6F, 7'h67, 7'h73, 7'h7F, 7'h0F};
    case ($urandom_range(0, 6))
      0: return {(f3 == 0 || f3 == 5) ? alt : 7'h00, rs2, rs1, f3, rd, 7'h33};
      1: begin
        if (f3 == 1) return {7'h00, rs2, rs1, f3, rd, 7'h13};
        if (f3 == 5) return {alt, rs2, rs1, f3, rd, 7'h13};
        return {imm, rs1, f3, rd, 7'h13};
      end
      2: return {imm, rs1, f3, rd, 7'h03};
      3: return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
      4: return {20'($urandom), rd, 7'h37};
      5: return {20'($urandom), rd, 7'h17};
      default: return {25'($urandom), bad[$urandom_range(0, 5)]};
    endcase
  endfunction

  initial begin
    rst = 1'b0;
    inst_i = 0; pc_i = 0; inst_valid_i = 0; stall_i = 0; flush_i = 0;
    reg1_data_i = 0; reg2_data_i = 0;
    quiet_fwd();
    m = '0;
    @(posedge clk); #1;
    check_all();
    rst = 1'b1;

    // Async reset mid-operation, then release with ADDI x1,x0,5
    drive(32'h0010_8193, 32'h40); reg1_data_i = 32'h1234;
    cycle();
    #2 rst = 1'b0;
    #1 m = '0;
    check_all();
    @(posedge clk); #1;
    rst = 1'b1;
    drive(32'h0050_0093, 32'h44);
    cycle();
    check_eq("addi_valid", ex_valid_o, 1);
    check_eq("addi_op2", ex_op2_o, 5);
    check_eq("addi_rd", ex_rd_o, 1);
    check_eq("addi_wreg", ex_wreg_o, 1);

    // Forwarding priority on ADD x3,x1,x2
    drive(32'h0020_81B3, 32'h48); reg1_data_i = 1; reg2_data_i = 32'h20;
    mem_fwd_we_i = 1; mem_fwd_waddr_i = 1; mem_fwd_wdata_i = 7;
    ex_fwd_we_i = 1; ex_fwd_waddr_i = 1; ex_fwd_wdata_i = 9;
    cycle();
    check_eq("fwd_ex_op1", ex_op1_o, 9);
    ex_fwd_we_i = 0;
    cycle();
    check_eq("fwd_mem_op1", ex_op1_o, 7);
    drive(32'h0000_81B3, 32'h4C); ex_fwd_we_i = 1; ex_fwd_waddr_i = 0; ex_fwd_wdata_i = 32'hDEAD;
    cycle();
    check_eq("fwd_x0_op2", ex_op2_o, 0);
    quiet_fwd();

    // Load-use: LW x2,0(x1) then ADD x4,x2,x2
    drive(32'h0000_A103, 32'h50);
    cycle();
    drive(32'h0021_0233, 32'h54);
    #1 check_eq("lu_stallreq", stallreq_o, 1);
    #0 ;
    begin : lu_bubble
      bundle_t b; b = m; b.valid = 0; b.wreg = 0; b.memop = 0; b.ill = 0;
      @(posedge clk); #1 m = b; check_all();
    end
    mem_fwd_we_i = 1; mem_fwd_waddr_i = 2; mem_fwd_wdata_i = 32'h55;
    cycle();
    check_eq("lu_op1", ex_op1_o, 32'h55);
    check_eq("lu_op2", ex_op2_o, 32'h55);
    check_eq("lu_valid", ex_valid_o, 1);
    quiet_fwd();

    // SUB x5,x6,x7 held by stall, then flush with stall
    drive(32'h4073_02B3, 32'h60); reg1_data_i = 100; reg2_data_i = 30;
    cycle();
    check_eq("sub_aluop", ex_aluop_o, 1);
    stall_i = 1; drive(32'h0050_0093, 32'h64);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("stall_pc", ex_pc_o, 32'h60);
    end
    flush_i = 1;
    cycle();
    check_eq("flush_valid", ex_valid_o, 0);
    check_eq("flush_wreg", ex_wreg_o, 0);
    stall_i = 0; flush_i = 0;

    // Immediate forms
    drive(32'h4030_D093, 32'h70); cycle();
    check_eq("srai_aluop", ex_aluop_o, 7);
    check_eq("srai_op2", ex_op2_o, 3);
    drive(32'hABCD_E437, 32'h74); cycle();
    check_eq("lui_op2", ex_op2_o, 32'hABCDE000);
    drive(32'h0000_1097, 32'h100); cycle();
    check_eq("auipc_op1", ex_op1_o, 32'h100);
    check_eq("auipc_op2", ex_op2_o, 32'h1000);
    drive(32'hFE31_2E23, 32'h104); cycle();
    check_eq("sw_op2", ex_op2_o, 32'hFFFFFFFC);
    check_eq("sw_memop", ex_memop_o, 2);
    check_eq("sw_wreg", ex_wreg_o, 0);

    // Illegal opcode and write to x0
    drive(32'h0000_007F, 32'h108); cycle();
    check_eq("ill_flag", ex_illegal_o, 1);
    check_eq("ill_wreg", ex_wreg_o, 0);
    drive(32'h0010_8013, 32'h10C); cycle();
    check_eq("x0_wreg", ex_wreg_o, 0);
    check_eq("x0_valid", ex_valid_o, 1);

    // Random streams
    for (int n = 0; n < 500; n++) begin
      inst_i = rand_inst();
      pc_i = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      inst_valid_i = ($urandom_range(0, 9) != 0);
      stall_i = ($urandom_range(0, 9) == 0);
      flush_i = ($urandom_range(0, 19) == 0);
      reg1_data_i = $urandom; reg2_data_i = $urandom;
      ex_fwd_we_i = $urandom_range(0, 1); ex_fwd_waddr_i = 5'($urandom_range(0, 3));
      ex_fwd_wdata_i = $urandom;
      mem_fwd_we_i = $urandom_range(0, 1); mem_fwd_waddr_i = 5'($urandom_range(0, 3));
      mem_fwd_wdata_i = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
